// File: rtl/ritc_idelay_pkg.sv
// Shared definitions for the RITC IDELAY loader: bus register map, tap address fields and FSM states.
package ritc_idelay_pkg;

  localparam int unsigned CH_W      = 2;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned TAP_W     = CH_W + IDX_W;
  localparam int unsigned DLY_W     = 5;
  localparam int unsigned DAT_W     = 8;
  localparam int unsigned NUM_CH    = 3;
  localparam int unsigned TBL_DEPTH = 64;

  localparam logic ADDR_DLY = 1'b0;
  localparam logic ADDR_TAP = 1'b1;
  localparam logic ADDR_RDY = 1'b0;

  localparam logic [IDX_W-1:0] CLK_IDX       = 4'hF;
  localparam logic [IDX_W-1:0] LAST_DATA_IDX = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POLL_RD,
    S_POLL_CHK,
    S_WR_DLY,
    S_WR_ADR,
    S_GAP,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [IDX_W-1:0] idx;
  } tap_t;

  // Lowest enabled channel at or above 'from'; MSB of the result flags that one exists.
  function automatic logic [CH_W:0] next_en_ch(input logic [NUM_CH-1:0] mask,
                                               input logic [CH_W:0]     from);
    logic [CH_W:0] res;
    res = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (i >= int'(from) && mask[i]) res = {1'b1, CH_W'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/ritc_idelay_loader_if.sv
// User register bus between the loader (master) and the RITC IDELAY decoder (slave).
interface ritc_idelay_loader_if;
  import ritc_idelay_pkg::*;

  logic             user_sel_o;
  logic             user_wr_o;
  logic             user_rd_o;
  logic             user_addr_o;
  logic [DAT_W-1:0] user_dat_o;
  logic [DAT_W-1:0] user_dat_i;

  modport master (
    output user_sel_o, user_wr_o, user_rd_o, user_addr_o, user_dat_o,
    input  user_dat_i
  );

  modport slave (
    input  user_sel_o, user_wr_o, user_rd_o, user_addr_o, user_dat_o,
    output user_dat_i
  );
endinterface

// File: rtl/ritc_idelay_table.sv
// 64x5 delay table: one synchronous write port, one combinational read port, async clear.
module ritc_idelay_table
  import ritc_idelay_pkg::*;
(
  input  logic             CLK,
  input  logic             rst_i,
  input  logic             we,
  input  logic [TAP_W-1:0] waddr,
  input  logic [DLY_W-1:0] wdat,
  input  logic [TAP_W-1:0] raddr,
  output logic [DLY_W-1:0] rdat
);
  logic [DLY_W-1:0] mem [TBL_DEPTH];

  always_ff @(posedge CLK or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(TBL_DEPTH); i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdat;
    end
  end

  assign rdat = mem[raddr];
endmodule

// File: rtl/ritc_idelay_loader.sv
// Programs every enabled RITC IDELAY tap over the user bus once all IDELAYCTRLs report ready.
// Optional poll timeout: define RITC_IDELAY_LOADER_TIMEOUT_EN.
module ritc_idelay_loader
  import ritc_idelay_pkg::*;
#(
  parameter int unsigned LOAD_GAP = 4,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic                  CLK,
  input  logic                  rst_i,
  input  logic                  tbl_wr_i,
  input  logic [TAP_W-1:0]      tbl_addr_i,
  input  logic [DLY_W-1:0]      tbl_dat_i,
  input  logic [NUM_CH-1:0]     ch_mask_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  ritc_idelay_loader_if.master  bus
);
  localparam int unsigned GAP_W = $clog2(LOAD_GAP + 1);

  state_t              state_q, state_d;
  tap_t                tap_q, tap_d;
  logic [NUM_CH-1:0]   mask_q;
  logic [GAP_W-1:0]    gap_q;
  logic [DLY_W-1:0]    tbl_rdat;
  logic                start_acc_c;
  logic                ready_c;
  logic                timeout_c;
  logic [CH_W:0]       first_ch_c, next_ch_c;

  logic                sel_d, wr_d, rd_d, addr_d, busy_d, done_d;
  logic [DAT_W-1:0]    dat_d;

  assign start_acc_c = start_i && (state_q == S_IDLE);
  assign ready_c     = (bus.user_dat_i[2:0] == 3'b111);
  assign first_ch_c  = next_en_ch(mask_q, '0);
  assign next_ch_c   = next_en_ch(mask_q, {1'b0, tap_q.ch} + (CH_W+1)'(1));

  ritc_idelay_table u_table (
    .CLK   (CLK),
    .rst_i (rst_i),
    .we    (tbl_wr_i && !busy_o),
    .waddr (tbl_addr_i),
    .wdat  (tbl_dat_i),
    .raddr (TAP_W'(tap_d)),
    .rdat  (tbl_rdat)
  );

  // State register
  always_ff @(posedge CLK or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and tap iterator
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    case (state_q)
      S_IDLE:     if (start_i) state_d = (ch_mask_i == '0) ? S_DONE : S_POLL_RD;
      S_POLL_RD:  state_d = S_POLL_CHK;
      S_POLL_CHK: begin
        if (ready_c) begin
          if (first_ch_c[CH_W]) begin
            state_d = S_WR_DLY;
            tap_d   = '{ch: first_ch_c[CH_W-1:0], idx: '0};
          end else begin
            state_d = S_DONE;
          end
        end else if (timeout_c) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_POLL_RD;
        end
      end
      S_WR_DLY:   state_d = S_WR_ADR;
      S_WR_ADR:   state_d = S_GAP;
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_WR_DLY;
          if (tap_q.idx == LAST_DATA_IDX) begin
            tap_d.idx = CLK_IDX;
          end else if (tap_q.idx == CLK_IDX) begin
            if (next_ch_c[CH_W]) tap_d = '{ch: next_ch_c[CH_W-1:0], idx: '0};
            else                 state_d = S_DONE;
          end else begin
            tap_d.idx = IDX_W'(tap_q.idx + IDX_W'(1));
          end
        end
      end
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output decode of the upcoming state; registered below so bus strobes align with it
  always_comb begin
    sel_d  = 1'b0;
    wr_d   = 1'b0;
    rd_d   = 1'b0;
    addr_d = 1'b0;
    dat_d  = '0;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      S_POLL_RD: begin
        sel_d = 1'b1; rd_d = 1'b1; busy_d = 1'b1; addr_d = ADDR_RDY;
      end
      S_POLL_CHK: busy_d = 1'b1;
      S_WR_DLY: begin
        sel_d = 1'b1; wr_d = 1'b1; busy_d = 1'b1; addr_d = ADDR_DLY;
        dat_d = DAT_W'(tbl_rdat);
      end
      S_WR_ADR: begin
        sel_d = 1'b1; wr_d = 1'b1; busy_d = 1'b1; addr_d = ADDR_TAP;
        dat_d = DAT_W'(TAP_W'(tap_d));
      end
      S_GAP:  busy_d = 1'b1;
      S_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge rst_i) begin
    if (rst_i) begin
      tap_q           <= '0;
      mask_q          <= '0;
      gap_q           <= '0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      bus.user_sel_o  <= 1'b0;
      bus.user_wr_o   <= 1'b0;
      bus.user_rd_o   <= 1'b0;
      bus.user_addr_o <= 1'b0;
      bus.user_dat_o  <= '0;
    end else begin
      tap_q           <= tap_d;
      if (start_acc_c) mask_q <= ch_mask_i;
      if (state_q == S_WR_ADR)   gap_q <= GAP_W'(LOAD_GAP - 1);
      else if (state_q == S_GAP) gap_q <= gap_q - GAP_W'(1);
      busy_o          <= busy_d;
      done_o          <= done_d;
      bus.user_sel_o  <= sel_d;
      bus.user_wr_o   <= wr_d;
      bus.user_rd_o   <= rd_d;
      bus.user_addr_o <= addr_d;
      bus.user_dat_o  <= dat_d;
    end
  end

`ifdef RITC_IDELAY_LOADER_TIMEOUT_EN
  localparam int unsigned POLL_W = $clog2(TIMEOUT + 1);
  logic [POLL_W-1:0] poll_q;
  logic              err_q;

  assign timeout_c = (poll_q == POLL_W'(TIMEOUT - 1));

  // Counts failed ready polls; err is sticky until the next accepted start
  always_ff @(posedge CLK or posedge rst_i) begin
    if (rst_i) begin
      poll_q <= '0;
      err_q  <= 1'b0;
    end else if (start_acc_c) begin
      poll_q <= '0;
      err_q  <= 1'b0;
    end else if (state_q == S_POLL_CHK && !ready_c) begin
      poll_q <= poll_q + POLL_W'(1);
      if (timeout_c) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign timeout_c = 1'b0;
  assign err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_ritc_idelay_loader.sv
// Randomized bench for ritc_idelay_loader against a transaction-list model of the sweep.
module tb_ritc_idelay_loader;
  import ritc_idelay_pkg::*;

  localparam int unsigned LOAD_GAP = 4;
`ifdef RITC_IDELAY_LOADER_TIMEOUT_EN
  localparam int unsigned TIMEOUT = 16;
`else
  localparam int unsigned TIMEOUT = 1024;
`endif

  logic       CLK        = 1'b0;
  logic       rst_i      = 1'b1;
  logic       tbl_wr_i   = 1'b0;
  logic [5:0] tbl_addr_i = '0;
  logic [4:0] tbl_dat_i  = '0;
  logic [2:0] ch_mask_i  = '0;
  logic       start_i    = 1'b0;
  logic       busy_o, done_o, err_o;
  logic [7:0] rsp_dat    = '0;

  ritc_idelay_loader_if bus_if ();
  assign bus_if.user_dat_i = rsp_dat;

  ritc_idelay_loader #(.LOAD_GAP(LOAD_GAP), .TIMEOUT(TIMEOUT)) dut (
    .CLK        (CLK),
    .rst_i      (rst_i),
    .tbl_wr_i   (tbl_wr_i),
    .tbl_addr_i (tbl_addr_i),
    .tbl_dat_i  (tbl_dat_i),
    .ch_mask_i  (ch_mask_i),
    .start_i    (start_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .bus        (bus_if.master)
  );

  always #5 CLK = ~CLK;

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [4:0] model_tbl [64];
  logic [8:0] obs_q [$];
  int         rd_cnt    = 0;
  int         done_cnt  = 0;
  int         busy_cnt  = 0;
  int         rsp_hold  = 0;
  logic [2:0] rsp_nr    = 3'b011;
  bit         rsp_stuck = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus monitor and IDELAYCTRL-ready responder, sampled mid-cycle
  always @(negedge CLK) begin
    if (bus_if.user_sel_o && bus_if.user_wr_o)
      obs_q.push_back({bus_if.user_addr_o, bus_if.user_dat_o});
    if (bus_if.user_sel_o && bus_if.user_rd_o) begin
      rd_cnt++;
      rsp_dat = (rsp_stuck || rd_cnt <= rsp_hold) ? {5'b0, rsp_nr} : 8'h07;
    end
    if (done_o) done_cnt++;
    if (busy_o) busy_cnt++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic tbl_write(input logic [5:0] a, input logic [4:0] d);
    tbl_wr_i = 1'b1; tbl_addr_i = a; tbl_dat_i = d;
    tick();
    tbl_wr_i = 1'b0;
    model_tbl[a] = d;
  endtask

  task automatic begin_run(input logic [2:0] mask, input int hold, input logic [2:0] nr);
    obs_q.delete();
    rd_cnt = 0; done_cnt = 0; busy_cnt = 0;
    rsp_hold = hold; rsp_nr = nr;
    start_i = 1'b1; ch_mask_i = mask;
    tick();
    start_i = 1'b0; ch_mask_i = ~mask;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy_o && n < 5000) begin
      tick();
      n++;
    end
    check({tag, " finish"}, 32'(busy_o), 32'd0);
    tick(); tick();
  endtask

  // Expected sweep: per enabled channel, idx 0..11 then 15, each a delay write then an address write
  task automatic verify(input string tag, input logic [2:0] mask, input int hold);
    logic [8:0] exp_q [$];
    int ntap;
    int idx;
    int a;
    ntap = 0;
    for (int ch = 0; ch < 3; ch++) begin
      if (mask[ch]) begin
        for (int k = 0; k < 13; k++) begin
          idx = (k == 12) ? 15 : k;
          a   = ch * 16 + idx;
          exp_q.push_back({1'b0, 3'b000, model_tbl[a]});
          exp_q.push_back({1'b1, 2'b00, 6'(a)});
          ntap++;
        end
      end
    end
    check({tag, " nwr"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s wr%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    check({tag, " reads"}, 32'(rd_cnt), 32'((ntap != 0) ? hold + 1 : 0));
    check({tag, " done"}, 32'(done_cnt), 32'd1);
    check({tag, " busy cycles"}, 32'(busy_cnt),
          32'((ntap != 0) ? 2 * (hold + 1) + ntap * (2 + int'(LOAD_GAP)) : 0));
    check({tag, " err"}, 32'(err_o), 32'd0);
  endtask

  initial begin
    logic [2:0] m;
    int         h;
    int         n;
    for (int i = 0; i < 64; i++) model_tbl[i] = '0;

    repeat (3) tick();
    check("rst busy", 32'(busy_o), 0);
    check("rst done", 32'(done_o), 0);
    check("rst err",  32'(err_o), 0);
    check("rst sel",  32'(bus_if.user_sel_o), 0);
    check("rst wr",   32'(bus_if.user_wr_o), 0);
    check("rst rd",   32'(bus_if.user_rd_o), 0);
    check("rst addr", 32'(bus_if.user_addr_o), 0);
    check("rst dat",  32'(bus_if.user_dat_o), 0);
    rst_i = 1'b0;
    tick();

    for (int i = 0; i < 64; i++) tbl_write(6'(i), 5'(i));
    begin_run(3'b111, 0, 3'b011); wait_idle("full"); verify("full", 3'b111, 0);

    begin_run(3'b111, 5, 3'b011); wait_idle("late"); verify("late", 3'b111, 5);

    begin_run(3'b010, 0, 3'b011); wait_idle("ch1"); verify("ch1", 3'b010, 0);

    begin_run(3'b000, 0, 3'b011); wait_idle("none"); verify("none", 3'b000, 0);

    for (int r = 0; r < 4; r++) begin
      repeat (8) tbl_write(6'($urandom_range(0, 63)), 5'($urandom));
      m = 3'($urandom_range(1, 7));
      h = int'($urandom_range(0, 3));
      begin_run(m, h, 3'($urandom_range(0, 6)));
      wait_idle($sformatf("rnd%0d", r));
      verify($sformatf("rnd%0d", r), m, h);
    end

    // Table write in the same cycle as start must be seen by the sweep
    tbl_wr_i = 1'b1; tbl_addr_i = 6'h05; tbl_dat_i = ~model_tbl[5];
    model_tbl[5] = ~model_tbl[5];
    begin_run(3'b001, 0, 3'b011);
    tbl_wr_i = 1'b0;
    wait_idle("same"); verify("same", 3'b001, 0);

    // Writes and starts while busy are ignored
    begin_run(3'b101, 1, 3'b110);
    repeat (10) begin
      tbl_wr_i = 1'b1;
      tbl_addr_i = {($urandom_range(0, 1) != 0) ? 2'd2 : 2'd0, 4'($urandom_range(0, 11))};
      tbl_dat_i = 5'($urandom);
      start_i = 1'b1; ch_mask_i = 3'b111;
      tick();
    end
    tbl_wr_i = 1'b0; start_i = 1'b0;
    wait_idle("busy"); verify("busy", 3'b101, 1);

    // Reset during the gap after tap 7
    begin_run(3'b111, 0, 3'b011);
    n = 0;
    while (obs_q.size() < 16 && n < 500) begin
      tick();
      n++;
    end
    check("mid tap7 reached", 32'(obs_q.size() >= 16), 1);
    if (obs_q.size() >= 16) check("mid tap7 addr", 32'(obs_q[15]), 32'h107);
    check("mid busy before", 32'(busy_o), 1);
    rst_i = 1'b1;
    #1;
    check("mid busy", 32'(busy_o), 0);
    check("mid done", 32'(done_o), 0);
    check("mid sel",  32'(bus_if.user_sel_o), 0);
    check("mid wr",   32'(bus_if.user_wr_o), 0);
    check("mid rd",   32'(bus_if.user_rd_o), 0);
    check("mid dat",  32'(bus_if.user_dat_o), 0);
    for (int i = 0; i < 64; i++) model_tbl[i] = '0;
    tick();
    rst_i = 1'b0;
    tick();
    begin_run(3'b111, 0, 3'b011); wait_idle("after rst"); verify("after rst", 3'b111, 0);

`ifdef RITC_IDELAY_LOADER_TIMEOUT_EN
    rsp_stuck = 1'b1;
    begin_run(3'b111, 0, 3'b000); wait_idle("tmo");
    check("tmo err",   32'(err_o), 1);
    check("tmo reads", 32'(rd_cnt), 32'(TIMEOUT));
    check("tmo nwr",   32'(obs_q.size()), 0);
    check("tmo done",  32'(done_cnt), 0);
    rsp_stuck = 1'b0;
    begin_run(3'b000, 0, 3'b011); wait_idle("tmo clr");
    check("tmo clr err",  32'(err_o), 0);
    check("tmo clr done", 32'(done_cnt), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ritc_idelay_loader.md
# ritc_idelay_loader

Bus initiator that programs every RITC input-delay tap (3 channels × 12 data bits + 1 clock) over the 8-bit user register bus consumed by the RITC IDELAY interface decoder. It holds a local 64×5 delay table, waits for all IDELAYCTRLs to report ready, then issues one delay-load per enabled tap. It sits between the control-register block (which fills the table and starts sweeps) and the RITC IDELAY block's user bus.

## Interface
Parameters:
- LOAD_GAP, 4: idle CLK cycles after each address write; must be ≥3 to cover the decoder's load-pulse extension and clock-domain crossing.
- TIMEOUT, 1024: maximum poll cycles waiting for IDELAYCTRL ready.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- tbl_wr_i  in  1  table write strobe; ignored while busy_o=1.
- tbl_addr_i  in  6  table index = {ch[1:0], idx[3:0]}.
- tbl_dat_i  in  5  delay tap value.
- ch_mask_i  in  3  channel enable, sampled at start.
- start_i  in  1  one-cycle start pulse; ignored while busy_o=1.
- busy_o  out  1  sequence in progress.
- done_o  out  1  one-cycle pulse at successful completion.
- err_o  out  1  sticky ready-timeout flag; cleared by next accepted start.
- user_sel_o, user_wr_o, user_rd_o  out  1 each  bus strobes, single-cycle.
- user_addr_o  out  1  register select.
- user_dat_o  out  8  write data.
- user_dat_i  in  8  read data.

## Operation
- Bus map: addr 0 write = delay value (dat[4:0]); addr 1 write = target {ch,idx} (dat[5:0]), which fires the load; addr 0 read = {5'b0, idelayctrl_rdy[2:0]}.
- Tap order per enabled channel (0→2): idx 0..11, then idx 15 (clock). Idx 12–14 never issued; 13 loads per channel, max 39.
- FSM: IDLE → POLL_RD → POLL_CHK → (WR_DLY → WR_ADR → GAP)* → DONE → IDLE.
- IDLE: start_i latches ch_mask_i, clears err_o, sets busy_o. Mask 3'b000 → DONE directly, no bus activity.
- POLL_RD: sel+rd, addr 0. POLL_CHK: sample user_dat_i[2:0]; 3'b111 → first tap; else → POLL_RD.
- WR_DLY: sel+wr, addr 0, dat = {3'b0, table[tap]}. WR_ADR: sel+wr, addr 1, dat = {2'b0, tap}. GAP: LOAD_GAP cycles, then next tap or DONE.
- Tap iterator: idx 11 → 15; idx 15 → idx 0 of next enabled channel; after last enabled channel → DONE.
- Table: 5-bit entries, reset to 0; all 64 writable, only tap addresses read.
- Reset mid-sequence: immediate return to IDLE, all strobes low, table cleared; a partially loaded IDELAY set is not repaired.

## Timing
- Reset values: busy_o, done_o, err_o, all strobes, user_addr_o, user_dat_o = 0.
- All bus outputs registered; strobes never high two consecutive cycles except POLL_RD/WR_DLY entry after GAP/CHK.
- Read data valid the cycle after user_rd_o; sampled in POLL_CHK.
- Per tap: 2 + LOAD_GAP cycles. Full sweep with ready first poll: 1 (start) + 2 (poll) + 39×(2+LOAD_GAP) + 1 (DONE) cycles.
- busy_o rises the cycle after start_i; done_o pulses in DONE; busy_o falls with it.
- start_i and tbl_wr_i in the same IDLE cycle: table write lands first, sequence sees new value.

## Configuration
- RITC_IDELAY_LOADER_TIMEOUT_EN defined: poll counter runs; reaching TIMEOUT polls → err_o=1, strobes low, IDLE, no done_o.
- Undefined: no counter; FSM polls indefinitely; err_o tied 0.

## Structure
- Package ritc_idelay_pkg: bus register addresses, tap address field widths, CLK_IDX = 4'hF, LAST_DATA_IDX = 4'd11, FSM state enum.
- Sub-module ritc_idelay_table: 64×5 register file, one write port, one async read port, async clear.

## Test plan
- Ready on first poll, mask 3'b111, table[i]=i[4:0] → 39 address writes in order 0x00..0x0B,0x0F,0x10..,0x2F; each preceded by delay write of matching value; done_o once.
- Ready returns 3'b011 for 5 polls then 3'b111 → 5 extra poll pairs, then normal sweep.
- Mask 3'b010 → only addresses 0x10–0x1B, 0x1F issued.
- With TIMEOUT_EN, TIMEOUT=16, ready stuck 3'b000 → err_o=1 after 16 polls, no writes; next start clears err_o.
- rst_i asserted during tap 7 GAP → all outputs 0 same cycle; subsequent start restarts at tap 0 with zeroed table.
- start_i and tbl_wr_i during busy → both ignored, sweep values unchanged.
